serial_to_parallel_aligner: RTL and testbench

Receive-side serial-to-parallel stage that feeds the 1:2 demux lane logic. It samples a single-bit MSB-first stream on `clk32f` and locks byte alignment on the COM character 0xBC. It then presents each received byte on `data_out_c` with a `valid_out_c` qualifier, held for one byte period (8 clocks). IDLE (0x7C) and COM (0xBC) bytes are delivered with `valid_out_c` low.

---
 rtl/serial_to_parallel_aligner.sv | 119 +++++++++++
 tb/tb_serial_to_parallel_aligner.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_aligner.sv
`default_nettype none
// ============================================================================
// Module   : serial_to_parallel_aligner
// Brief    : MSB-first serial-to-byte converter with COM-character alignment
//            lock. Optional macro S2P_BYTE_STROBE_EN adds a byte_strobe pulse.
// Revision : 1.0 - initial release
// ============================================================================
module serial_to_parallel_aligner #(
    parameter logic [7:0] COM        = 8'hBC,
    parameter logic [7:0] IDLE       = 8'h7C,
    parameter int         LOCK_COUNT = 4
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out_c,
    output logic       valid_out_c,
    output logic       active
`ifdef S2P_BYTE_STROBE_EN
    ,
    output logic       byte_strobe
`endif
);

    localparam logic [2:0] LOCK_TARGET = 3'(LOCK_COUNT);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic [2:0] com_cnt;

    logic [7:0] nxt;
    logic       boundary;
    logic       is_com;
    logic       is_payload;

    // Candidate byte includes the bit currently on the line.
    assign nxt        = {sr[6:0], data_in};
    assign boundary   = (bit_cnt == 3'd7);
    assign is_com     = (nxt == COM);
    assign is_payload = (nxt != COM) && (nxt != IDLE);

    always_ff @(posedge clk32f) begin
        if (reset) begin
            state       <= SEARCH;
            sr          <= 8'h00;
            bit_cnt     <= 3'd0;
            com_cnt     <= 3'd0;
            data_out_c  <= 8'h00;
            valid_out_c <= 1'b0;
            active      <= 1'b0;
`ifdef S2P_BYTE_STROBE_EN
            byte_strobe <= 1'b0;
`endif
        end else begin
            sr      <= nxt;
            bit_cnt <= bit_cnt + 3'd1;
`ifdef S2P_BYTE_STROBE_EN
            byte_strobe <= 1'b0;
`endif
            case (state)
                SEARCH: begin
                    // Any bit position may start a lock; the counter is
                    // re-phased so the next boundary lands 8 bits later.
                    if (is_com) begin
                        bit_cnt <= 3'd0;
                        if (LOCK_COUNT == 1) begin
                            state   <= ACTIVE;
                            active  <= 1'b1;
                            com_cnt <= 3'd0;
                        end else begin
                            state   <= LOCKING;
                            com_cnt <= 3'd1;
                        end
                    end
                end
                LOCKING: begin
                    if (boundary) begin
                        if (is_com) begin
                            if (com_cnt + 3'd1 == LOCK_TARGET) begin
                                state   <= ACTIVE;
                                active  <= 1'b1;
                                com_cnt <= 3'd0;
                            end else begin
                                com_cnt <= com_cnt + 3'd1;
                            end
                        end else begin
                            state   <= SEARCH;
                            com_cnt <= 3'd0;
                        end
                    end
                end
                ACTIVE: begin
                    // Lock is sticky until reset; every boundary delivers a byte.
                    if (boundary) begin
                        data_out_c  <= nxt;
                        valid_out_c <= is_payload;
`ifdef S2P_BYTE_STROBE_EN
                        byte_strobe <= 1'b1;
`endif
                    end
                end
                default: begin
                    state   <= SEARCH;
                    active  <= 1'b0;
                    com_cnt <= 3'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_to_parallel_aligner
// Brief    : Directed self-checking bench for serial_to_parallel_aligner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_to_parallel_aligner;

    logic       clk32f = 1'b0;
    logic       reset  = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out_c;
    logic       valid_out_c;
    logic       active;
`ifdef S2P_BYTE_STROBE_EN
    logic       byte_strobe;
`endif

    int errors = 0;
    int checks = 0;
    int bad_bc = 0;
    int cyc    = 0;
    int pulses = 0;
    int pulse_cyc [0:15];

    serial_to_parallel_aligner dut (
        .clk32f      (clk32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out_c  (data_out_c),
        .valid_out_c (valid_out_c),
        .active      (active)
`ifdef S2P_BYTE_STROBE_EN
        ,
        .byte_strobe (byte_strobe)
`endif
    );

    always #5 clk32f = ~clk32f;

    // Drive one bit, let the edge sample it, then observe #1 later.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk32f);
        #1;
        cyc++;
        if (valid_out_c === 1'b1 && data_out_c === 8'hBC) bad_bc++;
`ifdef S2P_BYTE_STROBE_EN
        if (byte_strobe === 1'b1) begin
            if (pulses < 16) pulse_cyc[pulses] = cyc;
            pulses++;
        end
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        data_in = 1'b0;
        repeat (2) @(posedge clk32f);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active); end
        checks++; if (data_out_c !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_out_c); end
        checks++; if (valid_out_c !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out_c); end
    endtask

    task automatic test_aligned_lock();
        logic [7:0] b;
        do_reset();
        repeat (3) send_byte(8'hBC);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL lock_early: active got %b expected 0", active); end
        send_byte(8'hBC);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL lock_at_32: active got %b expected 1", active); end
        checks++; if (data_out_c !== 8'h00 || valid_out_c !== 1'b0) begin errors++; $display("FAIL lock_com_hidden: got %h/%b expected 00/0", data_out_c, valid_out_c); end
        send_byte(8'h11);
        checks++; if (data_out_c !== 8'h11 || valid_out_c !== 1'b1) begin errors++; $display("FAIL byte_11: got %h/%b expected 11/1", data_out_c, valid_out_c); end
        b = 8'hFF;
        for (int i = 7; i >= 1; i--) begin
            send_bit(b[i]);
            checks++; if (data_out_c !== 8'h11 || valid_out_c !== 1'b1) begin errors++; $display("FAIL hold_11: got %h/%b expected 11/1", data_out_c, valid_out_c); end
        end
        send_bit(b[0]);
        checks++; if (data_out_c !== 8'hFF || valid_out_c !== 1'b1) begin errors++; $display("FAIL byte_ff: got %h/%b expected ff/1", data_out_c, valid_out_c); end
    endtask

    task automatic test_phase_offset();
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (3) send_byte(8'hBC);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL offset_early: active got %b expected 0", active); end
        send_byte(8'hBC);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL offset_lock: active got %b expected 1", active); end
        send_byte(8'h12);
        checks++; if (data_out_c !== 8'h12 || valid_out_c !== 1'b1) begin errors++; $display("FAIL offset_byte_12: got %h/%b expected 12/1", data_out_c, valid_out_c); end
    endtask

    task automatic test_broken_lock();
        do_reset();
        send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h55);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL broken_after_55: active got %b expected 0", active); end
        repeat (3) send_byte(8'hBC);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL broken_relock_early: active got %b expected 0", active); end
        send_byte(8'hBC);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL broken_relock: active got %b expected 1", active); end
        send_byte(8'h13);
        checks++; if (data_out_c !== 8'h13 || valid_out_c !== 1'b1) begin errors++; $display("FAIL broken_byte_13: got %h/%b expected 13/1", data_out_c, valid_out_c); end
    endtask

    // Continues from the locked state left by the previous test.
    task automatic test_filler();
        send_byte(8'h7C);
        checks++; if (data_out_c !== 8'h7C || valid_out_c !== 1'b0) begin errors++; $display("FAIL filler_idle: got %h/%b expected 7c/0", data_out_c, valid_out_c); end
        send_byte(8'hBC);
        checks++; if (data_out_c !== 8'hBC || valid_out_c !== 1'b0) begin errors++; $display("FAIL filler_com: got %h/%b expected bc/0", data_out_c, valid_out_c); end
        send_byte(8'h14);
        checks++; if (data_out_c !== 8'h14 || valid_out_c !== 1'b1) begin errors++; $display("FAIL filler_payload: got %h/%b expected 14/1", data_out_c, valid_out_c); end
    endtask

    task automatic test_reset_midstream();
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL mid_pre_active: got %b expected 1", active); end
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        reset = 1'b1;
        send_bit(1'b0);
        reset = 1'b0;
        checks++; if (active !== 1'b0 || data_out_c !== 8'h00 || valid_out_c !== 1'b0) begin errors++; $display("FAIL mid_reset: got %b/%h/%b expected 0/00/0", active, data_out_c, valid_out_c); end
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (3) send_byte(8'hBC);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL mid_relock_early: active got %b expected 0", active); end
        send_byte(8'hBC);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL mid_relock: active got %b expected 1", active); end
        send_byte(8'h16);
        checks++; if (data_out_c !== 8'h16 || valid_out_c !== 1'b1) begin errors++; $display("FAIL mid_byte_16: got %h/%b expected 16/1", data_out_c, valid_out_c); end
    endtask

`ifdef S2P_BYTE_STROBE_EN
    task automatic test_byte_strobe();
        do_reset();
        pulses = 0;
        repeat (4) send_byte(8'hBC);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL strobe_before_active: got %0d pulses expected 0", pulses); end
        send_byte(8'h21); send_byte(8'h7C); send_byte(8'h22);
        checks++; if (pulses !== 3) begin errors++; $display("FAIL strobe_count: got %0d expected 3", pulses); end
        if (pulses >= 3) begin
            checks++; if (pulse_cyc[1] - pulse_cyc[0] !== 8) begin errors++; $display("FAIL strobe_gap0: got %0d expected 8", pulse_cyc[1] - pulse_cyc[0]); end
            checks++; if (pulse_cyc[2] - pulse_cyc[1] !== 8) begin errors++; $display("FAIL strobe_gap1: got %0d expected 8", pulse_cyc[2] - pulse_cyc[1]); end
        end
        send_bit(1'b0);
        checks++; if (byte_strobe !== 1'b0) begin errors++; $display("FAIL strobe_single_cycle: got %b expected 0", byte_strobe); end
    endtask
`endif

    initial begin
        test_reset();
        test_aligned_lock();
        test_phase_offset();
        test_broken_lock();
        test_filler();
        test_reset_midstream();
`ifdef S2P_BYTE_STROBE_EN
        test_byte_strobe();
`endif
        // The filler test delivers a COM with valid low; any valid COM is an error.
        checks++; if (bad_bc !== 0) begin errors++; $display("FAIL com_delivered_valid: got %0d expected 0", bad_bc); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
